// File: rtl/conv_sched_pkg.sv
// -----------------------------------------------------------------------------
// conv_sched_pkg
// Shared types for the conv layer scheduler.
//   state_t      : scheduler FSM states
//   layer_cfg_t  : one config-table entry; bit layout matches cfg_wdata
//                  [11:0] in_len, [15:12] in_ch, [19:16] out_ch, [20] act_en,
//                  [31:21] wbase
//   cfg_is_valid : geometry sanity check applied before a layer is launched
// -----------------------------------------------------------------------------
package conv_sched_pkg;

  localparam int LEN_W   = 12;
  localparam int CH_W    = 4;
  localparam int WBASE_W = 11;
  localparam int CFG_W   = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_HOLD,
    ST_ERROR
  } state_t;

  // Declared MSB first so a plain cast of cfg_wdata lands every field.
  typedef struct packed {
    logic [WBASE_W-1:0] wbase;
    logic               act_en;
    logic [CH_W-1:0]    out_ch;
    logic [CH_W-1:0]    in_ch;
    logic [LEN_W-1:0]   in_len;
  } layer_cfg_t;

  // A layer is runnable only if the input covers at least one kernel window
  // and both channel counts are non-zero.
  function automatic logic cfg_is_valid(input layer_cfg_t c, input int unsigned kernel);
    return (32'(c.in_len) >= kernel) && (c.in_ch != '0) && (c.out_ch != '0);
  endfunction

endpackage

// File: rtl/conv_cfg_table.sv
// -----------------------------------------------------------------------------
// conv_cfg_table
// Per-layer configuration register file plus the num_layers register.
//   clk, rstn     : clock, synchronous active-low reset (clears everything)
//   i_we          : write strobe (caller gates it to the scheduler's IDLE state)
//   i_addr        : 0..MAX_LAYERS-1 = layer entry, MAX_LAYERS = num_layers,
//                   anything larger is ignored
//   i_wdata       : entry fields, or num_layers in [LIDX_W-1:0] (clamped)
//   i_rd_idx      : asynchronous read address
//   o_rd_cfg      : entry at i_rd_idx (zero when out of range)
//   o_rd_ok       : o_rd_cfg passes the geometry check
//   o_num_layers  : layers per frame
// -----------------------------------------------------------------------------
module conv_cfg_table
  import conv_sched_pkg::*;
#(
  parameter int MAX_LAYERS  = 8,
  parameter int KERNEL_SIZE = 5,
  parameter int LIDX_W      = $clog2(MAX_LAYERS + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_we,
  input  logic [LIDX_W-1:0] i_addr,
  input  logic [CFG_W-1:0]  i_wdata,
  input  logic [LIDX_W-1:0] i_rd_idx,
  output layer_cfg_t        o_rd_cfg,
  output logic              o_rd_ok,
  output logic [LIDX_W-1:0] o_num_layers
);

  localparam int AW = $clog2(MAX_LAYERS);
  localparam logic [LIDX_W-1:0] NUM_ADDR = LIDX_W'(MAX_LAYERS);

  layer_cfg_t        r_table [MAX_LAYERS];
  logic [LIDX_W-1:0] r_num_layers;
  logic [LIDX_W-1:0] w_num_wdata;

  assign w_num_wdata = i_wdata[LIDX_W-1:0];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      // NOTE: the table is a handful of flops, not a RAM macro, so it is
      // cleared on reset; a frame launched after reset then sees all-zero
      // entries and is rejected by the validity check instead of using junk.
      for (int i = 0; i < MAX_LAYERS; i++) r_table[i] <= '0;
      r_num_layers <= '0;
    end else if (i_we) begin
      if (i_addr == NUM_ADDR) begin
        r_num_layers <= (w_num_wdata > NUM_ADDR) ? NUM_ADDR : w_num_wdata;
      end else if (i_addr < NUM_ADDR) begin
        r_table[i_addr[AW-1:0]] <= layer_cfg_t'(i_wdata);
      end
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns o_rd_cfg and no latch is built.
    o_rd_cfg = '0;
    if (i_rd_idx < NUM_ADDR) o_rd_cfg = r_table[i_rd_idx[AW-1:0]];
  end

  assign o_rd_ok      = cfg_is_valid(o_rd_cfg, KERNEL_SIZE);
  assign o_num_layers = r_num_layers;

endmodule

// File: rtl/conv_layer_scheduler.sv
// -----------------------------------------------------------------------------
// conv_layer_scheduler
// Runs every layer of a 1D CNN frame through one shared conv engine, one layer
// per start/done handshake, ping-ponging between activation banks 0 and 1.
//   clk, rstn                : clock, synchronous active-low reset
//   cfg_we/cfg_addr/cfg_wdata: config table write port (honoured in IDLE only)
//   frame_valid/frame_ready  : frame handshake from the input loader (bank 0)
//   eng_start/eng_done       : engine start pulse / layer-finished pulse
//   eng_*                    : per-layer geometry, weight base, ReLU, banks
//   layer_idx                : layer currently running
//   busy                     : LAUNCH, WAIT or HOLD
//   result_valid/ready/bank  : result handshake to the classifier stage
//   error/err_clr            : sticky timeout / bad-config flag and its clear
// -----------------------------------------------------------------------------
module conv_layer_scheduler
  import conv_sched_pkg::*;
#(
  parameter int MAX_LAYERS     = 8,
  parameter int KERNEL_SIZE    = 5,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int LIDX_W         = $clog2(MAX_LAYERS + 1)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               cfg_we,
  input  logic [LIDX_W-1:0]  cfg_addr,
  input  logic [CFG_W-1:0]   cfg_wdata,
  input  logic               frame_valid,
  output logic               frame_ready,
  output logic               eng_start,
  input  logic               eng_done,
  output logic [LEN_W-1:0]   eng_in_len,
  output logic [LEN_W-1:0]   eng_out_len,
  output logic [CH_W-1:0]    eng_in_ch,
  output logic [CH_W-1:0]    eng_out_ch,
  output logic               eng_act_en,
  output logic [WBASE_W-1:0] eng_wbase,
  output logic               eng_src_bank,
  output logic               eng_dst_bank,
  output logic [LIDX_W-1:0]  layer_idx,
  output logic               busy,
  output logic               result_valid,
  input  logic               result_ready,
  output logic               result_bank,
  output logic               error,
  input  logic               err_clr
);

  localparam int                TMO_W     = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LEN_W-1:0]  K_MINUS_1 = LEN_W'(KERNEL_SIZE - 1);

  state_t             r_state;
  logic [LIDX_W-1:0]  r_layer_idx;
  logic [TMO_W-1:0]   r_tmo_cnt;
  logic               r_done;
  logic               r_eng_start;
  layer_cfg_t         r_cfg;
  logic [LEN_W-1:0]   r_eng_out_len;
  logic               r_src_bank;
  logic               r_dst_bank;
  logic               r_result_bank;

  logic               w_cfg_we;
  logic [LIDX_W-1:0]  w_rd_idx;
  layer_cfg_t         w_rd_cfg;
  logic               w_rd_ok;
  logic [LIDX_W-1:0]  w_num_layers;
  logic               w_last_layer;
  logic               w_launch;

  assign w_cfg_we = cfg_we && (r_state == ST_IDLE);

  // From IDLE the first layer is fetched; from WAIT, the layer after this one.
  assign w_rd_idx     = (r_state == ST_IDLE) ? '0 : (r_layer_idx + LIDX_W'(1));
  assign w_last_layer = (r_layer_idx == (w_num_layers - LIDX_W'(1)));

  // Status outputs decode registered state only: no input-to-output path.
  assign frame_ready  = (r_state == ST_IDLE) && (w_num_layers != '0);
  assign busy         = (r_state == ST_LAUNCH) || (r_state == ST_WAIT) || (r_state == ST_HOLD);
  assign result_valid = (r_state == ST_HOLD);
  assign error        = (r_state == ST_ERROR);

  // Entering LAUNCH from either side loads the engine registers.
  assign w_launch = ((r_state == ST_IDLE) && frame_valid && frame_ready) ||
                    ((r_state == ST_WAIT) && r_done && !w_last_layer);

  conv_cfg_table #(
    .MAX_LAYERS  (MAX_LAYERS),
    .KERNEL_SIZE (KERNEL_SIZE),
    .LIDX_W      (LIDX_W)
  ) u_cfg_table (
    .clk          (clk),
    .rstn         (rstn),
    .i_we         (w_cfg_we),
    .i_addr       (cfg_addr),
    .i_wdata      (cfg_wdata),
    .i_rd_idx     (w_rd_idx),
    .o_rd_cfg     (w_rd_cfg),
    .o_rd_ok      (w_rd_ok),
    .o_num_layers (w_num_layers)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state       <= ST_IDLE;
      r_layer_idx   <= '0;
      r_tmo_cnt     <= '0;
      r_done        <= 1'b0;
      r_eng_start   <= 1'b0;
      r_cfg         <= '0;
      r_eng_out_len <= '0;
      r_src_bank    <= 1'b0;
      r_dst_bank    <= 1'b0;
      r_result_bank <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every branch below reads the
      // pre-edge values of r_done, r_eng_start and r_tmo_cnt.
      // eng_done is registered once; pulses outside WAIT never reach the FSM.
      r_done      <= eng_done && (r_state == ST_WAIT);
      r_eng_start <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_launch) r_state <= ST_LAUNCH;
        end
        ST_LAUNCH: begin
          // r_eng_start was loaded with the entry's validity, so it doubles
          // as the go/no-go for this layer.
          r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
          r_state   <= r_eng_start ? ST_WAIT : ST_ERROR;
        end
        ST_WAIT: begin
          r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
          if (r_done) begin
            if (w_last_layer) begin
              r_state       <= ST_HOLD;
              r_result_bank <= w_num_layers[0];
            end else begin
              r_state <= ST_LAUNCH;
            end
          end else if (r_tmo_cnt == TMO_LAST) begin
            r_state <= ST_ERROR;
          end
        end
        ST_HOLD: begin
          if (result_ready) r_state <= ST_IDLE;
        end
        ST_ERROR: begin
          if (err_clr) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_launch) begin
        r_layer_idx   <= w_rd_idx;
        r_cfg         <= w_rd_cfg;
        r_eng_out_len <= w_rd_cfg.in_len - K_MINUS_1;
        r_src_bank    <= w_rd_idx[0];
        r_dst_bank    <= ~w_rd_idx[0];
        r_eng_start   <= w_rd_ok;
        r_tmo_cnt     <= '0;
      end
    end
  end

  assign eng_start    = r_eng_start;
  assign eng_in_len   = r_cfg.in_len;
  assign eng_out_len  = r_eng_out_len;
  assign eng_in_ch    = r_cfg.in_ch;
  assign eng_out_ch   = r_cfg.out_ch;
  assign eng_act_en   = r_cfg.act_en;
  assign eng_wbase    = r_cfg.wbase;
  assign eng_src_bank = r_src_bank;
  assign eng_dst_bank = r_dst_bank;
  assign layer_idx    = r_layer_idx;
  assign result_bank  = r_result_bank;

endmodule

// File: doc/conv_layer_scheduler.md
Name: conv_layer_scheduler

Overview:
Sequences a multi-layer 1D CNN frame through one shared, restartable conv engine using a start/done handshake. Holds a small per-layer configuration table and drives the engine's geometry, weight base, activation enable and ping-pong bank selects for each layer. Accepts frames from the input loader and hands a result-bank pointer to the dense/classifier stage. Guards the engine with a watchdog timeout.

Parameters:
MAX_LAYERS, 8, depth of the config table; the max layers per frame.
KERNEL_SIZE, 5, fixed kernel size of the shared engine.
TIMEOUT_CYCLES, 1000000, maximum cycles allowed in WAIT before the error state.
LIDX_W, $clog2(MAX_LAYERS+1), width of the layer index and config address.

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
cfg_we  in  1  config write strobe
cfg_addr  in  LIDX_W  0..MAX_LAYERS-1 selects a layer entry; MAX_LAYERS selects the num_layers register
cfg_wdata  in  32  entry fields: [11:0] in_len, [15:12] in_ch, [19:16] out_ch, [20] act_en, [31:21] wbase; for num_layers: [LIDX_W-1:0]
frame_valid  in  1  input buffer (bank 0) holds a new frame
frame_ready  out  1  scheduler can accept a frame
eng_start  out  1  one-cycle start pulse to the engine
eng_done  in  1  engine finished the current layer (1-cycle pulse)
eng_in_len  out  12  current layer input length
eng_out_len  out  12  in_len-KERNEL_SIZE+1
eng_in_ch  out  4  input channels
eng_out_ch  out  4  output channels
eng_act_en  out  1  1 = ReLU
eng_wbase  out  11  weight memory base word
eng_src_bank  out  1  source bank
eng_dst_bank  out  1  destination bank
layer_idx  out  LIDX_W  layer currently running
busy  out  1  state is not IDLE or ERROR
result_valid  out  1  frame result available
result_ready  in  1  consumer accepts the result
result_bank  out  1  bank holding the final layer output
error  out  1  sticky; set on timeout or bad config
err_clr  in  1  clears the error and returns to IDLE

Behaviour:
- Reset: state IDLE; all outputs 0; num_layers 0; all table entries 0; timeout counter 0. A reset mid-frame abandons the frame immediately.
- States: IDLE, LAUNCH, WAIT, HOLD, ERROR.
- IDLE:
  - frame_ready = (num_layers != 0).
  - Config writes are accepted only in IDLE. cfg_addr > MAX_LAYERS is ignored. A num_layers write > MAX_LAYERS is clamped to MAX_LAYERS.
  - On frame_valid & frame_ready: layer_idx <= 0, go to LAUNCH.
- Config validation: checked in LAUNCH. If in_len < KERNEL_SIZE, in_ch == 0 or out_ch == 0, go to ERROR and do not pulse eng_start.
- LAUNCH (exactly 1 cycle):
  - Register the eng_* fields from table[layer_idx]. eng_out_len = in_len-KERNEL_SIZE+1.
  - eng_src_bank = layer_idx[0]; eng_dst_bank = ~layer_idx[0].
  - eng_start = 1 this cycle only. Clear the timeout counter. Go to WAIT.
  - All eng_* outputs are stable from LAUNCH through the end of WAIT.
- WAIT:
  - Timeout counter increments each cycle.
  - eng_done while layer_idx < num_layers-1: layer_idx++, go to LAUNCH. The next eng_start lands 2 cycles after eng_done.
  - eng_done on the last layer: go to HOLD with result_bank = num_layers[0].
  - Counter reaching TIMEOUT_CYCLES-1 without eng_done: go to ERROR. If eng_done arrives on that same cycle, done wins.
- eng_done outside WAIT is ignored.
- HOLD: result_valid = 1. On result_valid & result_ready, go to IDLE. frame_ready stays 0 until IDLE, so the next frame handshake happens 1 cycle after result acceptance at the earliest.
- ERROR: error = 1, busy = 0, frame_ready = 0. err_clr returns to IDLE, clears error and keeps the table. err_clr outside ERROR is ignored.
- Frame latency: handshake cycle N → eng_start at N+1.

Decomposition:
- Package conv_sched_pkg:
  - state enum;
  - layer_cfg_t packed struct matching the cfg_wdata fields;
  - field width constants.
- One natural sub-module: conv_cfg_table (register file with a write port, an async read port and validity check logic).
- The FSM and watchdog live in the top module.

Test Plan:
- Program num_layers=2: L0 {in_len 784, in_ch 1, out_ch 4, act 1, wbase 0}, L1 {in_len 780, in_ch 4, out_ch 8, act 1, wbase 20}. Frame handshake at cycle N → eng_start at N+1 with out_len 780, src 0, dst 1. eng_done → eng_start 2 cycles later with out_len 776, src 1, dst 0, wbase 20. Final done → result_valid with result_bank 0.
- Hold result_ready low for 10 cycles → result_valid held, frame_ready 0, no eng_start. Raise result_ready → frame_ready = 1 on the next cycle.
- TIMEOUT_CYCLES=16, withhold eng_done → error = 1 exactly 16 cycles after eng_start. err_clr → IDLE; a new frame runs correctly with the table intact.
- Entry with in_len 3 → ERROR from LAUNCH and eng_start never asserted.
- cfg_we during WAIT → ignored: the next frame uses the old values. Pulse eng_done in IDLE → no state change.
- Assert rstn low during the WAIT of layer 1 → all outputs 0 and num_layers 0 next cycle; frame_ready 0 until reprogrammed.
